write_test_sequencer: RTL and testbench

Run controller for the 32-bit pipe-in write throughput test. It sits between the host trigger/wire endpoints and the pipe-in → FIFO → checker datapath. It clears the FIFO and pattern generator, starts the cycle timer on the first host word, and stops it when the programmed number of words has been checked. It then snapshots the checker error count and flags timeout and overflow conditions, replacing the manual start/stop timer triggers.

---
 rtl/write_test_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_write_test_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_test_sequencer.sv
// Run controller for the pipe-in write throughput test: clears the datapath, times the transfer
// from first host word to last checked word, and snapshots errors, timeout and overflow.
module write_test_sequencer #(
  parameter int unsigned LEN_W      = 32,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic             okClk,
  input  logic             reset,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] transfer_len_i,
  input  logic [LEN_W-1:0] timeout_cycles_i,
  input  logic             pipe_write_i,
  input  logic             fifo_valid_i,
  input  logic [LEN_W-1:0] error_count_i,
  output logic             fifo_rst_o,
  output logic             pattern_reset_o,
  output logic             timer_on_o,
  output logic [63:0]      clk_counts_o,
  output logic [LEN_W-1:0] words_in_o,
  output logic [LEN_W-1:0] words_checked_o,
  output logic [LEN_W-1:0] errors_latched_o,
  output logic [7:0]       status_o
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StClear     = 3'd1,
    StWaitFirst = 3'd2,
    StRun       = 3'd3,
    StSettle    = 3'd4,
    StDone      = 3'd5,
    StTimeout   = 3'd6
  } state_e;

  localparam int unsigned     ClrW    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [ClrW-1:0] ClrLast = ClrW'(CLR_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ClrW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  tmo_q, tmo_d;
  logic [LEN_W-1:0]  idle_q, idle_d;
  logic [63:0]       clk_counts_q, clk_counts_d;
  logic [LEN_W-1:0]  words_in_q, words_in_d;
  logic [LEN_W-1:0]  words_checked_q, words_checked_d;
  logic [LEN_W-1:0]  errors_q, errors_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              overflow_q, overflow_d;
  logic              timer_on_q, timer_on_d;
  logic              fifo_rst_q, fifo_rst_d;
  logic              pattern_reset_q, pattern_reset_d;
  logic              rearm_ok;

  assign rearm_ok = (state_q == StIdle) || (state_q == StDone) || (state_q == StTimeout);

  always_comb begin
    state_d         = state_q;
    clr_cnt_d       = clr_cnt_q;
    len_d           = len_q;
    tmo_d           = tmo_q;
    idle_d          = idle_q;
    clk_counts_d    = clk_counts_q;
    words_in_d      = words_in_q;
    words_checked_d = words_checked_q;
    errors_d        = errors_q;
    done_d          = done_q;
    timeout_d       = timeout_q;
    overflow_d      = overflow_q;
    timer_on_d      = timer_on_q;
    fifo_rst_d      = fifo_rst_q;
    pattern_reset_d = pattern_reset_q;

    if (abort_i && (state_q != StIdle)) begin
      // Counters and snapshot are left intact so the host can inspect a cancelled run.
      state_d         = StIdle;
      timer_on_d      = 1'b0;
      fifo_rst_d      = 1'b0;
      pattern_reset_d = 1'b0;
    end else if (arm_i && rearm_ok) begin
      state_d         = StClear;
      clr_cnt_d       = '0;
      len_d           = transfer_len_i;
      tmo_d           = timeout_cycles_i;
      idle_d          = '0;
      clk_counts_d    = '0;
      words_in_d      = '0;
      words_checked_d = '0;
      errors_d        = '0;
      done_d          = 1'b0;
      timeout_d       = 1'b0;
      overflow_d      = 1'b0;
      fifo_rst_d      = 1'b1;
      pattern_reset_d = 1'b1;
    end else begin
      case (state_q)
        StClear: begin
          clr_cnt_d = clr_cnt_q + ClrW'(1);
          if (clr_cnt_q == ClrLast) begin
            fifo_rst_d      = 1'b0;
            pattern_reset_d = 1'b0;
            if (len_q != '0) begin
              state_d = StWaitFirst;
            end else begin
              state_d  = StDone;
              done_d   = 1'b1;
              errors_d = '0;
            end
          end
        end
        StWaitFirst, StRun: begin
          idle_d = (pipe_write_i || fifo_valid_i) ? '0 : idle_q + LEN_W'(1);
          if (state_q == StWaitFirst) begin
            if (pipe_write_i) begin
              state_d      = StRun;
              clk_counts_d = 64'd1;
              timer_on_d   = 1'b1;
              words_in_d   = LEN_W'(1);
            end
          end else begin
            clk_counts_d = clk_counts_q + 64'd1;
            if (pipe_write_i) begin
              words_in_d = words_in_q + LEN_W'(1);
              if (words_in_q == len_q) overflow_d = 1'b1;
            end
            if (fifo_valid_i) begin
              words_checked_d = words_checked_q + LEN_W'(1);
              if (words_checked_q == len_q - LEN_W'(1)) begin
                state_d    = StSettle;
                timer_on_d = 1'b0;
              end
            end
          end
          if (!pipe_write_i && !fifo_valid_i && (tmo_q != '0) && (idle_d == tmo_q)) begin
            state_d    = StTimeout;
            timer_on_d = 1'b0;
            timeout_d  = 1'b1;
            errors_d   = error_count_i;
          end
        end
        // One cycle lets the registered checker fold in the final word before the snapshot.
        StSettle: begin
          errors_d = error_count_i;
          done_d   = 1'b1;
          state_d  = StDone;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      state_q         <= StIdle;
      clr_cnt_q       <= '0;
      len_q           <= '0;
      tmo_q           <= '0;
      idle_q          <= '0;
      clk_counts_q    <= '0;
      words_in_q      <= '0;
      words_checked_q <= '0;
      errors_q        <= '0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      overflow_q      <= 1'b0;
      timer_on_q      <= 1'b0;
      fifo_rst_q      <= 1'b0;
      pattern_reset_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      len_q           <= len_d;
      tmo_q           <= tmo_d;
      idle_q          <= idle_d;
      clk_counts_q    <= clk_counts_d;
      words_in_q      <= words_in_d;
      words_checked_q <= words_checked_d;
      errors_q        <= errors_d;
      done_q          <= done_d;
      timeout_q       <= timeout_d;
      overflow_q      <= overflow_d;
      timer_on_q      <= timer_on_d;
      fifo_rst_q      <= fifo_rst_d;
      pattern_reset_q <= pattern_reset_d;
    end
  end

  assign fifo_rst_o       = fifo_rst_q;
  assign pattern_reset_o  = pattern_reset_q;
  assign timer_on_o       = timer_on_q;
  assign clk_counts_o     = clk_counts_q;
  assign words_in_o       = words_in_q;
  assign words_checked_o  = words_checked_q;
  assign errors_latched_o = errors_q;
  assign status_o         = {1'b0, (errors_q != '0), overflow_q, timeout_q, done_q, state_q};

endmodule

// File: tb/tb_write_test_sequencer.sv
// Self-checking bench for write_test_sequencer: vector table, hand sequences for abort/reset/
// timeout, and randomized runs checked against an event-time model of the run.
module tb_write_test_sequencer;

  logic        okClk;
  logic        reset;
  logic        arm_i;
  logic        abort_i;
  logic [31:0] transfer_len_i;
  logic [31:0] timeout_cycles_i;
  logic        pipe_write_i;
  logic        fifo_valid_i;
  logic [31:0] error_count_i;
  logic        fifo_rst_o;
  logic        pattern_reset_o;
  logic        timer_on_o;
  logic [63:0] clk_counts_o;
  logic [31:0] words_in_o;
  logic [31:0] words_checked_o;
  logic [31:0] errors_latched_o;
  logic [7:0]  status_o;

  write_test_sequencer dut (
    .okClk            (okClk),
    .reset            (reset),
    .arm_i            (arm_i),
    .abort_i          (abort_i),
    .transfer_len_i   (transfer_len_i),
    .timeout_cycles_i (timeout_cycles_i),
    .pipe_write_i     (pipe_write_i),
    .fifo_valid_i     (fifo_valid_i),
    .error_count_i    (error_count_i),
    .fifo_rst_o       (fifo_rst_o),
    .pattern_reset_o  (pattern_reset_o),
    .timer_on_o       (timer_on_o),
    .clk_counts_o     (clk_counts_o),
    .words_in_o       (words_in_o),
    .words_checked_o  (words_checked_o),
    .errors_latched_o (errors_latched_o),
    .status_o         (status_o)
  );

  initial begin
    okClk = 1'b0;
    forever #5 okClk = ~okClk;
  end

  typedef struct {
    int     len;
    int     npw;
    int     gap;
    int     lag;
    int     err;
    int     arm_at;
    longint exp_clk;
    int     exp_win;
    int     exp_st;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   pw_edges[$];
  vec_t vecs[6];

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit has_pw(input int k);
    foreach (pw_edges[i]) if (pw_edges[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // Arm and walk through CLEAR; afterwards the next tick is the first edge a word can land on.
  task automatic do_arm(input int len, input int tmo);
    transfer_len_i   = 32'(len);
    timeout_cycles_i = 32'(tmo);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    chk("clear_fifo_rst_1", {63'd0, fifo_rst_o}, 64'd1);
    chk("clear_pat_rst_1", {63'd0, pattern_reset_o}, 64'd1);
    chk("clear_status", {56'd0, status_o}, 64'd1);
    tick();
    chk("clear_fifo_rst_2", {63'd0, fifo_rst_o}, 64'd1);
    tick();
    chk("clear_fifo_rst_end", {63'd0, fifo_rst_o}, 64'd0);
    chk("clear_clk_zeroed", clk_counts_o, 64'd0);
    chk("clear_words_zeroed", {32'd0, words_in_o}, 64'd0);
    chk("clear_state", {61'd0, status_o[2:0]}, (len != 0) ? 64'd2 : 64'd5);
  endtask

  // Words land on the edges in pw_edges; each is checked lag edges later.
  task automatic run_done(input string name, input int len, input int lag, input int err,
                          input int arm_at, input longint exp_clk, input int exp_win,
                          input int exp_st);
    int last_chk;
    int n_edges;
    last_chk = pw_edges[len-1] + lag;
    n_edges  = ((pw_edges[$] > last_chk) ? pw_edges[$] : last_chk) + 3;
    do_arm(len, 0);
    for (int k = 0; k < n_edges; k++) begin
      pipe_write_i   = has_pw(k);
      fifo_valid_i   = has_pw(k - lag);
      arm_i          = (k == arm_at);
      transfer_len_i = (k == arm_at) ? 32'd9 : 32'(len);
      error_count_i  = (k == last_chk + 1) ? 32'(err) : 32'(err) ^ 32'h55;
      tick();
      if (k == last_chk) begin
        chk({name, "_settle"}, {61'd0, status_o[2:0]}, 64'd4);
        chk({name, "_timer_off"}, {63'd0, timer_on_o}, 64'd0);
      end
    end
    pipe_write_i = 1'b0;
    fifo_valid_i = 1'b0;
    arm_i        = 1'b0;
    chk({name, "_clk_counts"}, clk_counts_o, 64'(exp_clk));
    chk({name, "_words_in"}, {32'd0, words_in_o}, 64'(exp_win));
    chk({name, "_words_checked"}, {32'd0, words_checked_o}, 64'(len));
    chk({name, "_status"}, {56'd0, status_o}, 64'(exp_st));
    chk({name, "_errors"}, {32'd0, errors_latched_o}, 64'(err));
  endtask

  // No checks arrive; the run must time out exactly tmo edges after the last word.
  task automatic run_timeout(input string name, input int len, input int tmo, input int err);
    int last_pw;
    last_pw = pw_edges[$];
    do_arm(len, tmo);
    error_count_i = 32'(err);
    for (int k = 0; k <= last_pw + tmo; k++) begin
      pipe_write_i = has_pw(k);
      tick();
      if (k == last_pw + tmo - 1) chk({name, "_still_run"}, {61'd0, status_o[2:0]}, 64'd3);
    end
    pipe_write_i = 1'b0;
    chk({name, "_status"}, {56'd0, status_o},
        64'(6 | 16 | ((err != 0) ? 64 : 0)));
    chk({name, "_timer_off"}, {63'd0, timer_on_o}, 64'd0);
    chk({name, "_words_in"}, {32'd0, words_in_o}, 64'(pw_edges.size()));
    chk({name, "_errors"}, {32'd0, errors_latched_o}, 64'(err));
  endtask

  initial begin
    reset            = 1'b1;
    arm_i            = 1'b0;
    abort_i          = 1'b0;
    transfer_len_i   = '0;
    timeout_cycles_i = '0;
    pipe_write_i     = 1'b0;
    fifo_valid_i     = 1'b0;
    error_count_i    = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_status", {56'd0, status_o}, 64'd0);
    chk("reset_fifo_rst", {63'd0, fifo_rst_o}, 64'd0);
    chk("reset_clk_counts", clk_counts_o, 64'd0);
    chk("reset_timer_on", {63'd0, timer_on_o}, 64'd0);

    //          len npw gap lag err arm_at clk win status
    vecs[0] = '{4, 4, 1, 2, 0, -1, 6, 4, 'h0D};
    vecs[1] = '{4, 4, 1, 2, 3, 2, 6, 4, 'h4D};
    vecs[2] = '{2, 3, 1, 2, 0, -1, 4, 3, 'h2D};
    vecs[3] = '{3, 3, 2, 1, 0, -1, 6, 3, 'h0D};
    vecs[4] = '{1, 1, 1, 1, 7, -1, 2, 1, 'h4D};
    vecs[5] = '{5, 7, 1, 3, 0, -1, 8, 7, 'h2D};
    foreach (vecs[v]) begin
      pw_edges.delete();
      for (int i = 0; i < vecs[v].npw; i++) pw_edges.push_back(i * vecs[v].gap);
      run_done($sformatf("vec%0d", v), vecs[v].len, vecs[v].lag, vecs[v].err, vecs[v].arm_at,
               vecs[v].exp_clk, vecs[v].exp_win, vecs[v].exp_st);
    end

    // Zero length completes straight out of CLEAR with an empty timer.
    do_arm(0, 0);
    chk("zero_len_status", {56'd0, status_o}, 64'h0D);
    chk("zero_len_clk", clk_counts_o, 64'd0);

    pw_edges.delete();
    pw_edges.push_back(0);
    pw_edges.push_back(1);
    run_timeout("timeout_basic", 8, 5, 0);

    // Abort mid-run: back to idle with counters frozen.
    do_arm(8, 0);
    for (int k = 0; k < 3; k++) begin
      pipe_write_i = 1'b1;
      tick();
    end
    pipe_write_i = 1'b0;
    chk("abort_timer_before", {63'd0, timer_on_o}, 64'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_state", {61'd0, status_o[2:0]}, 64'd0);
    chk("abort_timer_off", {63'd0, timer_on_o}, 64'd0);
    chk("abort_words_in", {32'd0, words_in_o}, 64'd3);
    tick();
    chk("abort_clk_held", clk_counts_o, 64'd3);

    // Reset mid-run clears every output.
    do_arm(8, 0);
    pipe_write_i = 1'b1;
    tick();
    tick();
    pipe_write_i = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_run_status", {56'd0, status_o}, 64'd0);
    chk("rst_run_clk", clk_counts_o, 64'd0);
    chk("rst_run_words", {32'd0, words_in_o}, 64'd0);
    chk("rst_run_timer", {63'd0, timer_on_o}, 64'd0);

    for (int r = 0; r < 20; r++) begin
      int     len;
      int     npw;
      int     lag;
      int     err;
      int     last_chk;
      int     win;
      longint clk;
      len = $urandom_range(1, 6);
      npw = len + $urandom_range(0, 2);
      lag = $urandom_range(1, 3);
      err = $urandom_range(0, 3);
      pw_edges.delete();
      pw_edges.push_back($urandom_range(0, 3));
      for (int i = 1; i < npw; i++) pw_edges.push_back(pw_edges[i-1] + $urandom_range(1, 3));
      last_chk = pw_edges[len-1] + lag;
      clk = longint'(last_chk - pw_edges[0] + 1);
      win = 0;
      foreach (pw_edges[i]) if (pw_edges[i] <= last_chk) win++;
      run_done($sformatf("rnd%0d", r), len, lag, err, -1, clk, win,
               5 | 8 | ((win > len) ? 32 : 0) | ((err != 0) ? 64 : 0));
    end

    for (int r = 0; r < 6; r++) begin
      int tmo;
      int npw;
      tmo = $urandom_range(3, 6);
      npw = $urandom_range(1, 4);
      pw_edges.delete();
      pw_edges.push_back(0);
      for (int i = 1; i < npw; i++) pw_edges.push_back(pw_edges[i-1] + $urandom_range(1, tmo - 1));
      run_timeout($sformatf("rnd_tmo%0d", r), 20, tmo, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
